// File: rtl/seq_detect_prog_pkg.sv
// Shared types and reset-time defaults for the programmable serial pattern detector.
package seq_detect_pkg;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam int          DEF_MAX_LEN     = 8;
    localparam int          DEF_CNT_W       = 16;
    localparam logic [7:0]  PKG_DEF_PATTERN = 8'b0000_1011;
    localparam int          PKG_DEF_LEN     = 4;
    localparam bit          PKG_DEF_OVERLAP = 1'b1;

    // Width that can hold every length 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Stream, configuration and status bundle of the pattern detector.
// Handshake: a bit is taken on every rising clk edge where din_valid=1; there is no back-pressure.
interface seq_detect_prog_if
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = len_w(MAX_LEN)
);
    logic               din_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clear_count;
    logic               match;
    logic [CNT_W-1:0]   hit_count;
    logic               cfg_err;
    logic               armed;
    state_t             dbg_state;
    logic [LEN_W-1:0]   dbg_fill;

    modport master (
        output din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear_count,
        input  match, hit_count, cfg_err, armed, dbg_state, dbg_fill
    );

    modport slave (
        input  din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear_count,
        output match, hit_count, cfg_err, armed, dbg_state, dbg_fill
    );
endinterface

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector: flags when the last len accepted bits equal
// the active pattern, with overlap/non-overlap modes and a saturating hit counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int               MAX_LEN     = DEF_MAX_LEN,
    parameter int               CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(PKG_DEF_PATTERN),
    parameter int               DEF_LEN     = PKG_DEF_LEN,
    parameter bit               DEF_OVERLAP = PKG_DEF_OVERLAP
) (
    input  logic            clk,
    input  logic            reset,
    seq_detect_prog_if.slave bus
);
    localparam int LEN_W = len_w(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] mask;
    logic               cfg_ok;
    logic               load_ok;
    logic               hit;
    logic               drop_fill;
    logic [CNT_W-1:0]   count;

    // History and fill as they would be if the current bit is accepted.
    always_comb begin
        hist_next = hist_q;
        fill_next = fill_q;
        if (bus.din_valid) begin
            hist_next = {hist_q[MAX_LEN-2:0], bus.din};
            if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_next = fill_q + LEN_W'(1);
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    assign load_ok   = bus.cfg_load && cfg_ok;
    // A load in the same cycle always swallows the incoming bit, even a rejected one.
    assign hit       = bus.din_valid && !bus.cfg_load && (fill_next >= len_q) &&
                       (((hist_next ^ pat_q) & mask) == '0);
    assign drop_fill = hit && !ovl_q;

    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = hit;
        cfg_err_d = bus.cfg_load && !cfg_ok;
        if (bus.cfg_load) begin
            if (cfg_ok) begin
                pat_d  = bus.cfg_pattern;
                len_d  = bus.cfg_len;
                ovl_d  = bus.cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end
        end else begin
            hist_d = hist_next;
            fill_d = drop_fill ? '0 : fill_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q     <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            ovl_q     <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // A non-overlap hit from ST_FILL empties the history, so it stays in ST_FILL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (!bus.cfg_load && (fill_next >= len_q) && !drop_fill) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (load_ok || drop_fill) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_comb begin
        bus.armed     = (state_q == ST_ARMED);
        bus.dbg_state = state_q;
        bus.dbg_fill  = fill_q;
        bus.match     = match_q;
        bus.cfg_err   = cfg_err_q;
        bus.hit_count = count;
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (bus.clear_count),
        .count (count)
    );
endmodule
